// File: rtl/password_store_arbiter_pkg.sv
// Shared types for the password store arbiter: FSM states, owner identities and store geometry.
package password_store_arbiter_pkg;

  localparam int DIGIT_W      = 4;
  localparam int DIGIT_ADDR_W = 2;
  localparam int PASSWORD_LEN = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2
  } ArbState;

  typedef enum logic {
    WRITER = 1'b0,
    READER = 1'b1
  } Owner;

  function automatic Owner otherOwner(input Owner o);
    return (o == WRITER) ? READER : WRITER;
  endfunction

endpackage

// File: rtl/password_store_arbiter_if.sv
// Requester handshakes plus the single store port, bundled so the arbiter sees one bus.
interface password_store_arbiter_if #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 4
);

  logic              wrReq;
  logic [ADDR_W-1:0] wrAddr;
  logic [DATA_W-1:0] wrData;
  logic              wrGrant;
  logic              rdReq;
  logic [ADDR_W-1:0] rdAddr;
  logic              rdGrant;
  logic              rdValid;
  logic [DATA_W-1:0] rdData;
  logic [ADDR_W-1:0] storeAddr;
  logic              storeWrite;
  logic [DATA_W-1:0] storeWData;
  logic [DATA_W-1:0] storeRData;

  modport master (
    output wrReq, wrAddr, wrData, rdReq, rdAddr, storeRData,
    input  wrGrant, rdGrant, rdValid, rdData, storeAddr, storeWrite, storeWData
  );

  modport slave (
    input  wrReq, wrAddr, wrData, rdReq, rdAddr, storeRData,
    output wrGrant, rdGrant, rdValid, rdData, storeAddr, storeWrite, storeWData
  );

endinterface

// File: rtl/password_store_arbiter_store_rr_picker.sv
// Round-robin pick between two requesters; on a tie the side that did not own the store last wins.
module store_rr_picker
  import password_store_arbiter_pkg::*;
(
  input  logic wrReq,
  input  logic rdReq,
  input  Owner lastOwner,
  output logic valid,
  output Owner winner
);

  always_comb begin
    valid  = wrReq | rdReq;
    winner = READER;
    if (wrReq && rdReq) begin
      winner = otherOwner(lastOwner);
    end else if (wrReq) begin
      winner = WRITER;
    end
  end

endmodule

// File: rtl/password_store_arbiter.sv
// Req/grant arbiter sharing the single-port password store between setter and validator,
// with round-robin ties, bounded bursts and a lockdown freeze.
module password_store_arbiter
  import password_store_arbiter_pkg::*;
#(
  parameter int ADDR_W    = DIGIT_ADDR_W,
  parameter int DATA_W    = DIGIT_W,
  parameter int MAX_BURST = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     lockDown,
  password_store_arbiter_if.slave  bus,
  output logic [1:0]               dbgArbState
);

  localparam int CNT_W = $clog2(MAX_BURST) + 1;

  ArbState           state;
  Owner              lastOwner;
  logic [CNT_W-1:0]  beatCnt;
  logic [ADDR_W-1:0] addrHold;
  logic [DATA_W-1:0] wDataHold;
  logic [DATA_W-1:0] rdDataHold;
  logic              rdValidQ;

  logic              pickValid;
  Owner              pickWinner;
  logic              wrGrant;
  logic              rdGrant;
  logic              ownerReq;
  logic              lastBeat;
  logic [ADDR_W-1:0] addrMux;
  logic [DATA_W-1:0] wDataMux;
  logic [DATA_W-1:0] rdDataMux;

  store_rr_picker picker (
    .wrReq     (bus.wrReq),
    .rdReq     (bus.rdReq),
    .lastOwner (lastOwner),
    .valid     (pickValid),
    .winner    (pickWinner)
  );

  always_comb begin
    wrGrant   = (state == S_WRITE) && bus.wrReq && !lockDown;
    rdGrant   = (state == S_READ)  && bus.rdReq && !lockDown;
    ownerReq  = (state == S_WRITE) ? bus.wrReq : bus.rdReq;
    lastBeat  = (wrGrant || rdGrant) && (beatCnt == CNT_W'(MAX_BURST - 1));
    addrMux   = addrHold;
    wDataMux  = wDataHold;
    case (state)
      S_WRITE: begin
        addrMux  = bus.wrAddr;
        wDataMux = bus.wrData;
      end
      S_READ:  addrMux = bus.rdAddr;
      default: ;
    endcase
    rdDataMux = rdValidQ ? bus.storeRData : rdDataHold;
  end

  assign bus.wrGrant    = wrGrant;
  assign bus.rdGrant    = rdGrant;
  assign bus.storeWrite = wrGrant;
  assign bus.storeAddr  = addrMux;
  assign bus.storeWData = wDataMux;
  assign bus.rdValid    = rdValidQ;
  assign bus.rdData     = rdDataMux;
  assign dbgArbState    = state;

  // Every release goes back through S_IDLE, so a waiting opposite side always sees one bubble.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= S_IDLE;
      beatCnt   <= '0;
      lastOwner <= READER;
    end else begin
      case (state)
        S_IDLE: begin
          if (!lockDown && pickValid) begin
            state     <= (pickWinner == WRITER) ? S_WRITE : S_READ;
            beatCnt   <= '0;
            lastOwner <= pickWinner;
          end
        end
        S_WRITE, S_READ: begin
          if (!ownerReq || lockDown || lastBeat) begin
            state <= S_IDLE;
          end else begin
            beatCnt <= beatCnt + CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      addrHold   <= '0;
      wDataHold  <= '0;
      rdDataHold <= '0;
      rdValidQ   <= 1'b0;
    end else begin
      addrHold   <= addrMux;
      wDataHold  <= wDataMux;
      rdDataHold <= rdDataMux;
      rdValidQ   <= rdGrant;
    end
  end

endmodule
